mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: IF/ID/EX/MEM/WB sequencer with HALT.
// Supports R-form, LW, SW, BEQ, J and ADDI, and flags every other opcode as
// illegal. Define MIPS_MC_PERF_EN to add the CYC_CNT/RET_CNT performance
// counters. Without that macro the ports and counters are absent and the
// controller behaves the same way.
module mips_mc_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic [5:0]  OP,
   input  logic [5:0]  FUNCT,
   input  logic        ZERO,
   input  logic        MEM_ACK,
   input  logic        HALT_REQ,
   output logic        PC_WE,
   output logic        IR_WE,
   output logic        RF_WE,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic        RETIRE,
   output logic        ILLEGAL,
   output logic [1:0]  ALU_OP,
   output logic [1:0]  ALU_SRC_B,
   output logic [1:0]  PC_SRC,
   output logic [2:0]  STATE
`ifdef MIPS_MC_PERF_EN
   ,
   output logic [31:0] CYC_CNT,
   output logic [31:0] RET_CNT
`endif
);

   // The STATE encoding is visible on the port, so the values are pinned.
   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_ADDI = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_BRANCH = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   state_t      state_reg;
   state_t      state_next;
   state_t      retire_target;
   logic [5:0]  op_reg;
   logic [5:0]  funct_reg;
   logic        if_first_reg;
   logic        halt_pend_reg;
   logic        halt_now;

   // Ungated control values. The port values are these with reset applied.
   logic        pc_we_int;
   logic        ir_we_int;
   logic        rf_we_int;
   logic        mem_req_int;
   logic        mem_we_int;
   logic        retire_int;
   logic        illegal_int;
   logic [1:0]  alu_op_int;
   logic [1:0]  alu_src_b_int;
   logic [1:0]  pc_src_int;

   // The datapath's ALU decoder reads FUNCT. The controller holds it for the
   // rest of the instruction, but no sequencing decision depends on it.
   logic [5:0]  unused_funct;
   assign unused_funct = funct_reg;

   // A halt request counts when it is present now or was seen earlier in
   // the current instruction. Both cases stop the next fetch.
   assign halt_now      = HALT_REQ | halt_pend_reg;
   assign retire_target = halt_now ? S_HALT : S_IF;

   // State register, opcode latch, first-cycle-of-IF flag and pending-halt latch.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= S_IF;
         op_reg        <= '0;
         funct_reg     <= '0;
         if_first_reg  <= 1'b1;
         halt_pend_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_ID) begin
            op_reg    <= OP;
            funct_reg <= FUNCT;
         end
         if_first_reg  <= (state_next == S_IF) && (state_reg != S_IF);
         halt_pend_reg <= halt_pend_reg | HALT_REQ;
      end
   end

   // Next-state logic and raw strobes for each state.
   always_comb begin
      state_next    = state_reg;
      pc_we_int     = 1'b0;
      ir_we_int     = 1'b0;
      rf_we_int     = 1'b0;
      mem_req_int   = 1'b0;
      mem_we_int    = 1'b0;
      retire_int    = 1'b0;
      illegal_int   = 1'b0;
      alu_op_int    = ALU_ADD;
      alu_src_b_int = SRCB_REG;
      pc_src_int    = PCS_ALU;

      case (state_reg)
         S_IF: begin
            // Normally the previous instruction's exit has already
            // redirected a halt. This branch handles a request that is
            // already present on the first cycle after reset.
            if (if_first_reg && halt_now) begin
               state_next = S_HALT;
            end else begin
               mem_req_int   = 1'b1;
               alu_src_b_int = SRCB_FOUR;
               if (MEM_ACK) begin
                  ir_we_int  = 1'b1;
                  pc_we_int  = 1'b1;
                  pc_src_int = PCS_ALU;
                  state_next = S_ID;
               end
            end
         end

         S_ID: begin
            state_next = S_EX;
         end

         S_EX: begin
            case (op_reg)
               OPC_R: begin
                  alu_op_int    = ALU_FUNCT;
                  alu_src_b_int = SRCB_REG;
                  state_next    = S_WB;
               end
               OPC_ADDI: begin
                  alu_op_int    = ALU_ADD;
                  alu_src_b_int = SRCB_IMM;
                  state_next    = S_WB;
               end
               OPC_LW, OPC_SW: begin
                  alu_op_int    = ALU_ADD;
                  alu_src_b_int = SRCB_IMM;
                  state_next    = S_MEM;
               end
               OPC_BEQ: begin
                  alu_op_int = ALU_SUB;
                  pc_src_int = PCS_BRANCH;
                  pc_we_int  = ZERO;
                  retire_int = 1'b1;
                  state_next = retire_target;
               end
               OPC_J: begin
                  pc_src_int = PCS_JUMP;
                  pc_we_int  = 1'b1;
                  retire_int = 1'b1;
                  state_next = retire_target;
               end
               default: begin
                  illegal_int = 1'b1;
                  retire_int  = 1'b1;
                  state_next  = retire_target;
               end
            endcase
         end

         S_MEM: begin
            mem_req_int = 1'b1;
            mem_we_int  = (op_reg == OPC_SW);
            if (MEM_ACK) begin
               if (op_reg == OPC_SW) begin
                  retire_int = 1'b1;
                  state_next = retire_target;
               end else begin
                  state_next = S_WB;
               end
            end
         end

         S_WB: begin
            rf_we_int  = 1'b1;
            retire_int = 1'b1;
            state_next = retire_target;
         end

         S_HALT: begin
            state_next = S_HALT;
         end

         default: begin
            state_next = S_IF;
         end
      endcase
   end

   // Hold every output quiet during a reset cycle so that a pending memory
   // request is dropped immediately.
   always_comb begin
      PC_WE     = pc_we_int     & ~RST;
      IR_WE     = ir_we_int     & ~RST;
      RF_WE     = rf_we_int     & ~RST;
      MEM_REQ   = mem_req_int   & ~RST;
      MEM_WE    = mem_we_int    & ~RST;
      RETIRE    = retire_int    & ~RST;
      ILLEGAL   = illegal_int   & ~RST;
      ALU_OP    = RST ? 2'b00 : alu_op_int;
      ALU_SRC_B = RST ? 2'b00 : alu_src_b_int;
      PC_SRC    = RST ? 2'b00 : pc_src_int;
   end

   assign STATE = state_reg;

`ifdef MIPS_MC_PERF_EN
   logic [31:0] cyc_cnt_reg;
   logic [31:0] ret_cnt_reg;

   // Free-running cycle and retirement counters. Both wrap naturally at 2^32.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cyc_cnt_reg <= '0;
         ret_cnt_reg <= '0;
      end else begin
         if (state_reg != S_HALT) begin
            cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
         end
         if (retire_int) begin
            ret_cnt_reg <= ret_cnt_reg + 32'd1;
         end
      end
   end

   assign CYC_CNT = cyc_cnt_reg;
   assign RET_CNT = ret_cnt_reg;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. Each instruction is checked against
// a transaction-level model: the expected latency, the state trail, the
// number of strobes of each kind and the control values in EX.
module tb_mips_mc_ctrl;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_ADDI = 6'b001000;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [5:0]  OP = '0;
   logic [5:0]  FUNCT = '0;
   logic        ZERO = 1'b0;
   logic        MEM_ACK = 1'b0;
   logic        HALT_REQ = 1'b0;
   logic        PC_WE, IR_WE, RF_WE, MEM_REQ, MEM_WE, RETIRE, ILLEGAL;
   logic [1:0]  ALU_OP, ALU_SRC_B, PC_SRC;
   logic [2:0]  STATE;
`ifdef MIPS_MC_PERF_EN
   logic [31:0] CYC_CNT, RET_CNT;
`endif

   int vectors = 0;
   int miscompares = 0;

   mips_mc_ctrl dut (
      .CLK(CLK), .RST(RST), .OP(OP), .FUNCT(FUNCT), .ZERO(ZERO),
      .MEM_ACK(MEM_ACK), .HALT_REQ(HALT_REQ),
      .PC_WE(PC_WE), .IR_WE(IR_WE), .RF_WE(RF_WE), .MEM_REQ(MEM_REQ),
      .MEM_WE(MEM_WE), .RETIRE(RETIRE), .ILLEGAL(ILLEGAL),
      .ALU_OP(ALU_OP), .ALU_SRC_B(ALU_SRC_B), .PC_SRC(PC_SRC), .STATE(STATE)
`ifdef MIPS_MC_PERF_EN
      , .CYC_CNT(CYC_CNT), .RET_CNT(RET_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reset for n rising edges, then release just after an edge.
   task automatic do_reset(input int n);
      @(negedge CLK);
      RST = 1'b1;
      repeat (n) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
   endtask

   // Run one instruction from IF entry until it retires, then compare
   // what happened with the model.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                            input logic zero, input int if_wait,
                            input int mem_wait, input string tag,
                            output int cycles_out);
      int cyc = 0, if_cnt = 0, mem_cnt = 0;
      int n_ir = 0, n_ret = 0, n_rf = 0, n_req = 0, n_we = 0, n_pcwe = 0, n_ill = 0;
      bit done = 0, fetch_ok = 1, rf_last = 0, seq_ok = 1;
      logic [1:0] ex_alu = '0, ex_srcb = '0, ex_pcsrc = '0;
      logic ex_pcwe = 1'b0;
      logic [2:0] seen[$];
      logic [2:0] want[$];
      bit is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_ill, is_mem, is_wb;
      int exp_lat, exp_req, exp_we, exp_pcwe;

      OP = op; FUNCT = funct; ZERO = zero;
      while (!done && cyc < 64) begin
         @(negedge CLK);
         if (STATE == 3'd0)      MEM_ACK = (if_cnt >= if_wait);
         else if (STATE == 3'd3) MEM_ACK = (mem_cnt >= mem_wait);
         else                    MEM_ACK = 1'($urandom_range(0, 1));
         #1;
         seen.push_back(STATE);
         if (STATE == 3'd0) if_cnt++;
         if (STATE == 3'd3) mem_cnt++;
         if (IR_WE)   n_ir++;
         if (RETIRE)  n_ret++;
         if (RF_WE)   n_rf++;
         if (MEM_REQ) n_req++;
         if (MEM_WE)  n_we++;
         if (PC_WE)   n_pcwe++;
         if (ILLEGAL) n_ill++;
         if (IR_WE && !(PC_WE && PC_SRC == 2'b00 && ALU_SRC_B == 2'b01)) fetch_ok = 0;
         if (STATE == 3'd2) begin
            ex_alu = ALU_OP; ex_srcb = ALU_SRC_B; ex_pcsrc = PC_SRC; ex_pcwe = PC_WE;
         end
         cyc++;
         if (RETIRE) begin done = 1; rf_last = RF_WE; end
      end
      cycles_out = cyc;

      // Model: derive the expected instruction behaviour from the opcode.
      is_r = (op == OPC_R);   is_addi = (op == OPC_ADDI);
      is_lw = (op == OPC_LW); is_sw = (op == OPC_SW);
      is_beq = (op == OPC_BEQ); is_j = (op == OPC_J);
      is_ill = !(is_r || is_addi || is_lw || is_sw || is_beq || is_j);
      is_mem = is_lw || is_sw;
      is_wb = is_r || is_addi || is_lw;
      exp_lat = (is_lw ? 5 : (is_r || is_addi || is_sw) ? 4 : 3)
                + if_wait + (is_mem ? mem_wait : 0);
      exp_req = if_wait + 1 + (is_mem ? mem_wait + 1 : 0);
      exp_we = is_sw ? mem_wait + 1 : 0;
      exp_pcwe = 1 + (is_j ? 1 : 0) + ((is_beq && zero) ? 1 : 0);
      for (int i = 0; i <= if_wait; i++) want.push_back(3'd0);
      want.push_back(3'd1);
      want.push_back(3'd2);
      if (is_mem) for (int i = 0; i <= mem_wait; i++) want.push_back(3'd3);
      if (is_wb) want.push_back(3'd4);

      if (seen.size() != want.size()) seq_ok = 0;
      else for (int i = 0; i < want.size(); i++) if (seen[i] !== want[i]) seq_ok = 0;

      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL %s retire: no RETIRE within %0d cycles, required one", tag, cyc);
      end
      vectors++;
      if (cyc !== exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d cycles, required %0d", tag, cyc, exp_lat);
      end
      vectors++;
      if (!seq_ok) begin
         miscompares++;
         $display("FAIL %s state_trail: got %0d states (first %0d), required %0d states", tag,
                  seen.size(), seen[0], want.size());
      end
      vectors++;
      if (n_ir !== 1 || !fetch_ok) begin
         miscompares++;
         $display("FAIL %s fetch: IR_WE count %0d ok=%0d, required 1 ok=1", tag, n_ir, fetch_ok);
      end
      vectors++;
      if (n_ret !== 1) begin
         miscompares++;
         $display("FAIL %s retire_count: got %0d, required 1", tag, n_ret);
      end
      vectors++;
      if (n_rf !== int'(is_wb) || (is_wb && !rf_last)) begin
         miscompares++;
         $display("FAIL %s rf_we: got count %0d last=%0d, required %0d", tag, n_rf, rf_last, is_wb);
      end
      vectors++;
      if (n_req !== exp_req) begin
         miscompares++;
         $display("FAIL %s mem_req_cycles: got %0d, required %0d", tag, n_req, exp_req);
      end
      vectors++;
      if (n_we !== exp_we) begin
         miscompares++;
         $display("FAIL %s mem_we_cycles: got %0d, required %0d", tag, n_we, exp_we);
      end
      vectors++;
      if (n_pcwe !== exp_pcwe) begin
         miscompares++;
         $display("FAIL %s pc_we_count: got %0d, required %0d", tag, n_pcwe, exp_pcwe);
      end
      vectors++;
      if (n_ill !== int'(is_ill)) begin
         miscompares++;
         $display("FAIL %s illegal_count: got %0d, required %0d", tag, n_ill, is_ill);
      end
      if (is_r || is_addi || is_mem) begin
         vectors++;
         if ({ex_alu, ex_srcb, ex_pcwe} !== {(is_r ? 2'b10 : 2'b00), (is_r ? 2'b00 : 2'b10), 1'b0}) begin
            miscompares++;
            $display("FAIL %s ex_alu: got op=%b srcb=%b pcwe=%b, required op=%b srcb=%b pcwe=0",
                     tag, ex_alu, ex_srcb, ex_pcwe, (is_r ? 2'b10 : 2'b00), (is_r ? 2'b00 : 2'b10));
         end
      end
      if (is_beq) begin
         vectors++;
         if ({ex_alu, ex_pcsrc, ex_pcwe} !== {2'b01, 2'b01, zero}) begin
            miscompares++;
            $display("FAIL %s ex_beq: got op=%b pcsrc=%b pcwe=%b, required op=01 pcsrc=01 pcwe=%b",
                     tag, ex_alu, ex_pcsrc, ex_pcwe, zero);
         end
      end
      if (is_j) begin
         vectors++;
         if ({ex_pcsrc, ex_pcwe} !== {2'b10, 1'b1}) begin
            miscompares++;
            $display("FAIL %s ex_j: got pcsrc=%b pcwe=%b, required pcsrc=10 pcwe=1", tag, ex_pcsrc, ex_pcwe);
         end
      end
      if (is_ill) begin
         vectors++;
         if (ex_pcwe !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ex_illegal_pcwe: got %b, required 0", tag, ex_pcwe);
         end
      end
      $display("instr %s op=%b funct=%b zero=%b ifw=%0d memw=%0d cycles=%0d", tag, op, funct, zero,
               if_wait, mem_wait, cyc);
   endtask

   task automatic test_reset;
      OP = 6'($urandom); MEM_ACK = 1'b1; HALT_REQ = 1'b0; ZERO = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      vectors++;
      if ({PC_WE, IR_WE, RF_WE, MEM_REQ, MEM_WE, RETIRE, ILLEGAL, ALU_OP, ALU_SRC_B, PC_SRC} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_quiet: got outputs %b, required all zero",
                  {PC_WE, IR_WE, RF_WE, MEM_REQ, MEM_WE, RETIRE, ILLEGAL, ALU_OP, ALU_SRC_B, PC_SRC});
      end
      vectors++;
      if (STATE !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_state: got %0d, required 0", STATE);
      end
      @(posedge CLK);
      #1 RST = 1'b0; MEM_ACK = 1'b0;
      #1;
      vectors++;
      if ({STATE, MEM_REQ, ALU_SRC_B, IR_WE} !== {3'd0, 1'b1, 2'b01, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_first_fetch: got state=%0d req=%b srcb=%b ir_we=%b, required 0 1 01 0",
                  STATE, MEM_REQ, ALU_SRC_B, IR_WE);
      end
`ifdef MIPS_MC_PERF_EN
      vectors++;
      if ({CYC_CNT, RET_CNT} !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_counters: got cyc=%0d ret=%0d, required 0 0", CYC_CNT, RET_CNT);
      end
`endif
      $display("reset checked");
   endtask

   task automatic test_sll;
      int c;
      run_instr(OPC_R, 6'b000000, 1'b0, 0, 0, "sll", c);
   endtask

   task automatic test_lw_wait;
      int c;
      run_instr(OPC_LW, 6'($urandom), 1'b0, 0, 3, "lw_wait", c);
      vectors++;
      if (c !== 8) begin
         miscompares++;
         $display("FAIL lw_wait_total: got %0d cycles, required 8", c);
      end
   endtask

   task automatic test_beq;
      int c;
      run_instr(OPC_BEQ, 6'($urandom), 1'b1, 0, 0, "beq_taken", c);
      run_instr(OPC_BEQ, 6'($urandom), 1'b0, 0, 0, "beq_not_taken", c);
   endtask

   task automatic test_illegal;
      int c;
      run_instr(6'b111111, 6'($urandom), 1'b0, 0, 0, "illegal", c);
   endtask

   task automatic test_random;
      logic [5:0] ops[7];
      logic [5:0] op;
      int c, total = 0;
`ifdef MIPS_MC_PERF_EN
      logic [31:0] cyc0, ret0;
      cyc0 = CYC_CNT; ret0 = RET_CNT;
`endif
      ops[0] = OPC_R; ops[1] = OPC_LW; ops[2] = OPC_SW; ops[3] = OPC_BEQ;
      ops[4] = OPC_J; ops[5] = OPC_ADDI; ops[6] = 6'b111111;
      for (int k = 0; k < 30; k++) begin
         op = ops[$urandom_range(0, 6)];
         if (op == 6'b111111) op = 6'($urandom);
         run_instr(op, 6'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), "random", c);
         total += c;
      end
`ifdef MIPS_MC_PERF_EN
      vectors++;
      if ((CYC_CNT - cyc0) !== 32'(total) || (RET_CNT - ret0) !== 32'd30) begin
         miscompares++;
         $display("FAIL perf_delta: got cyc+%0d ret+%0d, required cyc+%0d ret+30",
                  CYC_CNT - cyc0, RET_CNT - ret0, total);
      end
`endif
   endtask

   // Reset during a data-memory wait in SW, then during a fetch wait.
   task automatic test_reset_mid;
      for (int k = 0; k < 2; k++) begin
         int cyc = 0, in_target = 0;
         bit hit = 0, ret_seen = 0;
         logic [2:0] target;
         target = (k == 0) ? 3'd3 : 3'd0;
         OP = OPC_SW; FUNCT = '0; ZERO = 1'b0; HALT_REQ = 1'b0;
         while (!hit && cyc < 40) begin
            @(negedge CLK);
            MEM_ACK = (k == 0) && (STATE == 3'd0);
            #1;
            cyc++;
            if (RETIRE) ret_seen = 1;
            if (STATE == target) begin
               in_target++;
               if (in_target == 2) hit = 1;
            end
         end
         RST = 1'b1;
         #1;
         vectors++;
         if (!hit || ret_seen || {MEM_REQ, MEM_WE, RETIRE, IR_WE} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_%0d: hit=%0d retired=%0d req=%b we=%b ret=%b ir=%b, required 1 0 0 0 0 0",
                     target, hit, ret_seen, MEM_REQ, MEM_WE, RETIRE, IR_WE);
         end
         @(posedge CLK);
         #1 RST = 1'b0; MEM_ACK = 1'b0;
         #1;
         vectors++;
         if ({STATE, MEM_REQ} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid_%0d_refetch: got state=%0d req=%b, required 0 1", target, STATE, MEM_REQ);
         end
`ifdef MIPS_MC_PERF_EN
         vectors++;
         if ({CYC_CNT, RET_CNT} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_counters: got cyc=%0d ret=%0d, required 0 0", CYC_CNT, RET_CNT);
         end
`endif
         $display("reset during state %0d checked", target);
      end
   endtask

   task automatic test_halt_mid;
      int cyc = 0, bad = 0, req_cnt = 0;
      bit retired = 0, saw_rf = 0;
      OP = OPC_ADDI; FUNCT = 6'($urandom); HALT_REQ = 1'b0;
      while (!retired && cyc < 40) begin
         @(negedge CLK);
         MEM_ACK = (STATE == 3'd0);
         #1;
         cyc++;
         if (STATE == 3'd2) HALT_REQ = 1'b1;
         if (RETIRE) begin retired = 1; saw_rf = RF_WE; end
      end
      vectors++;
      if (!retired || !saw_rf) begin
         miscompares++;
         $display("FAIL halt_wb_completes: retired=%0d rf_we=%0d, required 1 1", retired, saw_rf);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         MEM_ACK = 1'($urandom_range(0, 1));
         #1;
         if (MEM_REQ) req_cnt++;
         if (STATE !== 3'd5 || {PC_WE, IR_WE, RF_WE, MEM_REQ, MEM_WE, RETIRE, ILLEGAL} !== 7'd0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL halt_hold: %0d bad cycles (mem_req in %0d), required 0", bad, req_cnt);
      end
      $display("halt after addi checked");
   endtask

   // HALT_REQ present as reset releases: no fetch, straight into HALT.
   task automatic test_halt_entry;
      int c;
      HALT_REQ = 1'b1;
      do_reset(2);
      vectors++;
      if ({STATE, MEM_REQ} !== {3'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL halt_entry_if: got state=%0d req=%b, required 0 0", STATE, MEM_REQ);
      end
      @(posedge CLK);
      #1;
      vectors++;
      if (STATE !== 3'd5) begin
         miscompares++;
         $display("FAIL halt_entry_state: got %0d, required 5", STATE);
      end
      HALT_REQ = 1'b0;
      do_reset(1);
      run_instr(OPC_J, 6'($urandom), 1'b0, 1, 0, "after_halt", c);
   endtask

   initial begin
      test_reset();
      test_sll();
      test_lw_wait();
      test_beq();
      test_illegal();
      test_random();
      test_reset_mid();
      test_halt_mid();
      test_halt_entry();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
